deque_mover: RTL and testbench



---
 rtl/deque_pkg.sv | 25 ++
 rtl/deque_mover.sv | 148 ++++++++++++++
 tb/tb_deque_mover.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/deque_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : deque_pkg
//  Brief    : Shared types and constants for the dual-deque mover.
//  Revision : 1.0 - initial release
// ============================================================================
package deque_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PEEK = 3'd1,
        POP  = 3'd2,
        PUSH = 3'd3,
        DONE = 3'd4
    } mover_state_t;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_SRC_EMPTY = 2'b01;
    localparam logic [1:0] ST_DST_FULL  = 2'b10;

    localparam logic END_FRONT = 1'b0;
    localparam logic END_BACK  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/deque_mover.sv
`default_nettype none
// ============================================================================
//  Module   : deque_mover
//  Brief    : Moves N bytes from one deque end to another (transfer/rotate).
//  Revision : 1.0 - initial release
// ============================================================================
module deque_mover
    import deque_pkg::*;
#(
    parameter int COUNT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_src_deque,
    input  logic                  cmd_src_end,
    input  logic                  cmd_dst_deque,
    input  logic                  cmd_dst_end,
    input  logic [COUNT_BITS-1:0] cmd_count,
    output logic                  deque_select,
    output logic                  end_select,
    output logic                  push,
    output logic                  pop,
    output logic [7:0]            data_in,
    input  logic [7:0]            data_out,
    input  logic [1:0]            empty,
    input  logic [1:0]            full,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status,
    output logic [COUNT_BITS-1:0] moved
);

    mover_state_t          r_state;
    logic                  r_src_deque;
    logic                  r_src_end;
    logic                  r_dst_deque;
    logic                  r_dst_end;
    logic [COUNT_BITS-1:0] r_remaining;
    logic [COUNT_BITS-1:0] r_moved;
    logic [7:0]            r_hold;
    logic [1:0]            r_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_src_deque <= 1'b0;
            r_src_end   <= END_FRONT;
            r_dst_deque <= 1'b0;
            r_dst_end   <= END_FRONT;
            r_remaining <= '0;
            r_moved     <= '0;
            r_hold      <= 8'h00;
            r_status    <= ST_OK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_src_deque <= cmd_src_deque;
                        r_src_end   <= cmd_src_end;
                        r_dst_deque <= cmd_dst_deque;
                        r_dst_end   <= cmd_dst_end;
                        r_remaining <= cmd_count;
                        r_moved     <= '0;
                        if (cmd_count == '0) begin
                            r_status <= ST_OK;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= PEEK;
                        end
                    end
                end
                PEEK: begin
                    // A rotation within one deque frees its own slot, so full is irrelevant there.
                    if (empty[r_src_deque]) begin
                        r_status <= ST_SRC_EMPTY;
                        r_state  <= DONE;
                    end else if (full[r_dst_deque] && (r_dst_deque != r_src_deque)) begin
                        r_status <= ST_DST_FULL;
                        r_state  <= DONE;
                    end else begin
                        r_state  <= POP;
                    end
                end
                POP: begin
                    r_hold  <= data_out;
                    r_state <= PUSH;
                end
                PUSH: begin
                    r_moved     <= r_moved + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                    if (r_remaining == {{(COUNT_BITS-1){1'b0}}, 1'b1}) begin
                        r_status <= ST_OK;
                        r_state  <= DONE;
                    end else begin
                        r_state  <= PEEK;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are a pure decode of registered state, so reset clears them immediately.
    always_comb begin
        deque_select = 1'b0;
        end_select   = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        data_in      = 8'h00;
        done         = 1'b0;
        case (r_state)
            PEEK: begin
                deque_select = r_src_deque;
                end_select   = r_src_end;
            end
            POP: begin
                deque_select = r_src_deque;
                end_select   = r_src_end;
                pop          = 1'b1;
            end
            PUSH: begin
                deque_select = r_dst_deque;
                end_select   = r_dst_end;
                push         = 1'b1;
                data_in      = r_hold;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign cmd_ready = ~busy;
    assign status    = r_status;
    assign moved     = r_moved;

endmodule
`default_nettype wire

// File: tb/tb_deque_mover.sv
`default_nettype none
// ============================================================================
//  Module   : tb_deque_mover
//  Brief    : Directed self-checking bench with a two-deque bus model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_deque_mover;

    localparam int CB = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_src_deque = 1'b0;
    logic          cmd_src_end = 1'b0;
    logic          cmd_dst_deque = 1'b0;
    logic          cmd_dst_end = 1'b0;
    logic [CB-1:0] cmd_count = '0;
    logic          deque_select;
    logic          end_select;
    logic          push;
    logic          pop;
    logic [7:0]    data_in;
    logic [7:0]    data_out;
    logic [1:0]    empty;
    logic [1:0]    full;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [CB-1:0] moved;

    always #5 clk = ~clk;

    deque_mover #(.COUNT_BITS(CB)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_src_deque (cmd_src_deque),
        .cmd_src_end   (cmd_src_end),
        .cmd_dst_deque (cmd_dst_deque),
        .cmd_dst_end   (cmd_dst_end),
        .cmd_count     (cmd_count),
        .deque_select  (deque_select),
        .end_select    (end_select),
        .push          (push),
        .pop           (pop),
        .data_in       (data_in),
        .data_out      (data_out),
        .empty         (empty),
        .full          (full),
        .busy          (busy),
        .done          (done),
        .status        (status),
        .moved         (moved)
    );

    // Two 16-entry deques; index 0 is the front. Selection is latched each edge.
    logic [7:0] mem [2][16];
    int         cnt [2] = '{0, 0};
    logic       sel_d = 1'b0;
    logic       sel_e = 1'b0;
    logic       clr = 1'b0;
    logic       ld = 1'b0;
    logic       ld_dq = 1'b0;
    logic [7:0] ld_val = 8'h00;

    function automatic logic [7:0] top_of(input logic d, input logic e);
        int n;
        n = cnt[int'(d)];
        if (n == 0) return 8'h00;
        return e ? mem[int'(d)][n-1] : mem[int'(d)][0];
    endfunction

    always_comb data_out = top_of(sel_d, sel_e);
    assign empty = {cnt[1] == 0, cnt[0] == 0};
    assign full  = {cnt[1] == 16, cnt[0] == 16};

    always @(posedge clk) begin : model
        logic [7:0] t [2][16];
        int         c [2];
        int         d;
        t = mem;
        c = cnt;
        if (clr) begin
            c[0] = 0;
            c[1] = 0;
        end else if (ld) begin
            d = int'(ld_dq);
            t[d][c[d]] = ld_val;
            c[d]++;
        end else begin
            d = int'(deque_select);
            if (pop && c[d] > 0) begin
                if (!end_select)
                    for (int i = 0; i < 15; i++) t[d][i] = t[d][i+1];
                c[d]--;
            end
            if (push && c[d] < 16) begin
                if (end_select) begin
                    t[d][c[d]] = data_in;
                end else begin
                    for (int i = 15; i > 0; i--) t[d][i] = t[d][i-1];
                    t[d][0] = data_in;
                end
                c[d]++;
            end
        end
        mem   <= t;
        cnt   <= c;
        sel_d <= deque_select;
        sel_e <= end_select;
    end

    int         checks = 0;
    int         failures = 0;
    int         done_cyc;
    int         npush;
    int         npop;
    logic       overlap;
    logic       pop_empty;
    logic       busy_bad;
    logic [7:0] pushed [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_all();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    task automatic load(input logic q, input logic [7:0] v);
        @(negedge clk); ld = 1'b1; ld_dq = q; ld_val = v;
        @(negedge clk); ld = 1'b0;
    endtask

    task automatic accept(input logic sd, input logic se, input logic dd,
                          input logic de, input logic [CB-1:0] n);
        @(negedge clk);
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_src_deque = sd; cmd_src_end = se;
        cmd_dst_deque = dd; cmd_dst_end = de;
        cmd_count = n; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        // Garbage on the command port while busy must be ignored.
        cmd_count = '1; cmd_src_deque = ~sd; cmd_dst_end = ~de;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic sd, input logic se, input logic dd,
                           input logic de, input logic [CB-1:0] n);
        accept(sd, se, dd, de, n);
        done_cyc = 0; npush = 0; npop = 0;
        overlap = 1'b0; pop_empty = 1'b0; busy_bad = 1'b0;
        for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (!busy || cmd_ready) busy_bad = 1'b1;
            if (push && pop) overlap = 1'b1;
            if (pop && empty[deque_select]) pop_empty = 1'b1;
            if (push && npush < 32) begin pushed[npush] = data_in; npush++; end
            if (pop) npop++;
            if (done) done_cyc = cyc;
        end
        chk("busy_during_cmd_bad", {31'd0, busy_bad}, 32'd0);
        chk("push_pop_overlap", {31'd0, overlap}, 32'd0);
        chk("pop_on_empty", {31'd0, pop_empty}, 32'd0);
    endtask

    task automatic check_idle_after();
        @(negedge clk);
        chk("idle_after_done", {29'd0, busy, done, cmd_ready}, 32'b001);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ctrl", {29'd0, cmd_ready, busy, done}, 32'b100);
        chk("rst_status_moved", {25'd0, status, moved}, 32'd0);
        chk("rst_bus", {20'd0, deque_select, end_select, push, pop, data_in}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Transfer 3 bytes: deque 0 front -> deque 1 back
        load(1'b0, 8'h11); load(1'b0, 8'h22); load(1'b0, 8'h33);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 5'd3);
        chk("t1_done_cycle", done_cyc, 32'd10);
        chk("t1_status", {30'd0, status}, 32'd0);
        chk("t1_moved", {27'd0, moved}, 32'd3);
        chk("t1_npush", npush, 32'd3);
        chk("t1_push_data", {8'd0, pushed[0], pushed[1], pushed[2]}, 32'h00112233);
        check_idle_after();
        chk("t1_cnt0", cnt[0], 32'd0);
        chk("t1_d1_order", {8'd0, mem[1][0], mem[1][1], mem[1][2]}, 32'h00112233);

        // Source runs dry: 2 bytes, count 5
        clear_all();
        load(1'b0, 8'hAA); load(1'b0, 8'hBB);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
        chk("t2_done_cycle", done_cyc, 32'd8);
        chk("t2_status", {30'd0, status}, 32'd1);
        chk("t2_moved", {27'd0, moved}, 32'd2);
        chk("t2_npop", npop, 32'd2);
        check_idle_after();
        chk("t2_d1_front_push", {16'd0, mem[1][0], mem[1][1]}, 32'h0000BBAA);

        // Destination full
        clear_all();
        for (int i = 0; i < 16; i++) load(1'b1, 8'(i + 8'h40));
        load(1'b0, 8'h01); load(1'b0, 8'h02); load(1'b0, 8'h03);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 5'd4);
        chk("t3_done_cycle", done_cyc, 32'd2);
        chk("t3_status", {30'd0, status}, 32'd2);
        chk("t3_moved", {27'd0, moved}, 32'd0);
        chk("t3_npop", npop, 32'd0);
        check_idle_after();
        chk("t3_cnt0_cnt1", {cnt[0][15:0], cnt[1][15:0]}, {16'd3, 16'd16});

        // Zero count: no bus activity, status returns to OK
        run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        chk("t5_done_cycle", done_cyc, 32'd1);
        chk("t5_status_moved", {25'd0, status, moved}, 32'd0);
        chk("t5_activity", npush + npop, 32'd0);
        check_idle_after();

        // Rotate a full deque by 4
        clear_all();
        for (int i = 0; i < 16; i++) load(1'b0, 8'(i));
        run_cmd(1'b0, 1'b0, 1'b0, 1'b1, 5'd4);
        chk("t4_done_cycle", done_cyc, 32'd13);
        chk("t4_status", {30'd0, status}, 32'd0);
        chk("t4_moved", {27'd0, moved}, 32'd4);
        check_idle_after();
        chk("t4_cnt0", cnt[0], 32'd16);
        chk("t4_rot_ends", {mem[0][0], mem[0][11], mem[0][12], mem[0][15]}, 32'h040F0003);

        // Asynchronous reset in a POP cycle, then a clean command
        clear_all();
        load(1'b0, 8'h5A); load(1'b0, 8'h6B); load(1'b0, 8'h7C);
        accept(1'b0, 1'b0, 1'b1, 1'b1, 5'd3);
        done_cyc = 0;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (pop) done_cyc = cyc;
        end
        chk("t6_pop_seen_cycle", done_cyc, 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_ctrl", {29'd0, cmd_ready, busy, pop}, 32'b100);
        chk("t6_async_bus", {22'd0, deque_select, end_select, data_in}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        chk("t6_ready_after", {31'd0, cmd_ready}, 32'd1);
        chk("t6_cnt0_kept", cnt[0], 32'd3);
        run_cmd(1'b0, 1'b0, 1'b1, 1'b1, 5'd3);
        chk("t6_done_cycle", done_cyc, 32'd10);
        chk("t6_status_moved", {25'd0, status, moved}, {25'd0, 2'b00, 5'd3});
        chk("t6_push_data", {8'd0, pushed[0], pushed[1], pushed[2]}, 32'h005A6B7C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
